// File: rtl/fib_seq_checker.sv
// -----------------------------------------------------------------------------
// fib_seq_checker
//
// Downstream consumer of a Fibonacci term generator. Each incoming term is
// counted, checked against the recurrence t[i] = t[i-1] + t[i-2] (mod 2^WIDTH)
// and buffered in a small first-word-fall-through FIFO that drains over a
// valid/ready handshake. Status reports the first mismatching term index, the
// number of terms in the current sequence and whether any term was dropped
// because the FIFO was full.
//
// Ports
//   clk        in   system clock, all state updates on the rising edge
//   rst        in   synchronous reset, active low
//   seq_start  in   one-cycle pulse: a new sequence starts (status/history clear)
//   in_valid   in   in_data carries a term this cycle
//   in_data    in   term value [WIDTH]
//   out_valid  out  FIFO head is valid
//   out_data   out  FIFO head value [WIDTH], zero while empty
//   out_ready  in   downstream takes the head this cycle
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   level      out  FIFO occupancy [clog2(DEPTH)+1]
//   term_count out  terms seen since last seq_start, saturating [IDXW]
//   err        out  sticky recurrence mismatch flag for the current sequence
//   err_index  out  index of first mismatch, meaningful while err=1 [IDXW]
//   overflow   out  sticky: a term was dropped on a full FIFO
// -----------------------------------------------------------------------------
module fib_seq_checker #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int IDXW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     seq_start,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [IDXW-1:0]          term_count,
    output logic                     err,
    output logic [IDXW-1:0]          err_index,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0]   LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
    localparam logic [IDXW-1:0] CNT_MAX    = {IDXW{1'b1}};
    localparam logic [IDXW-1:0] CNT_ONE    = IDXW'(1);
    localparam logic [IDXW-1:0] FIRST_CHK  = IDXW'(2);

    // Recurrence prediction; the sum is truncated so wrap-around is legal.
    function automatic logic [WIDTH-1:0] fib_sum(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] s;
        s = a + b;
        return s;
    endfunction

    // ---------------------------------------------------------------- state
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r,      wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_r,      rd_ptr_nxt_s;
    logic [LW-1:0]    level_r,       level_nxt_s;
    logic             full_r,        full_nxt_s;
    logic             empty_r,       empty_nxt_s;
    logic [IDXW-1:0]  term_count_r,  term_count_nxt_s;
    logic             err_r,         err_nxt_s;
    logic [IDXW-1:0]  err_index_r,   err_index_nxt_s;
    logic             overflow_r,    overflow_nxt_s;
    logic [WIDTH-1:0] p1_r,          p1_nxt_s;
    logic [WIDTH-1:0] p2_r,          p2_nxt_s;

    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             mismatch_s;
    logic [WIDTH-1:0] expected_s;

    // Handshake decode: a pop frees a slot, so a full FIFO can still accept.
    always_comb begin
        pop_s  = (~empty_r) & out_ready;
        push_s = in_valid & ((~full_r) | pop_s);
        drop_s = in_valid & full_r & (~pop_s);
    end

    // FIFO pointer and occupancy next-state; flags derive from the new level
    // so full, empty and level can never disagree.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LEVEL_ONE;
            2'b01:   level_nxt_s = level_r - LEVEL_ONE;
            default: level_nxt_s = level_r;
        endcase
        full_nxt_s  = (level_nxt_s == FULL_LEVEL);
        empty_nxt_s = (level_nxt_s == {LW{1'b0}});
    end

    // Recurrence check. A seq_start term is index 0 of the new sequence and is
    // never checked; otherwise indices 0 and 1 are seeds.
    always_comb begin
        expected_s = fib_sum(p1_r, p2_r);
        if (in_valid && !seq_start && (term_count_r >= FIRST_CHK)) begin
            mismatch_s = (in_data != expected_s);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Sequence status and history next-state.
    always_comb begin
        term_count_nxt_s = term_count_r;
        err_nxt_s        = err_r;
        err_index_nxt_s  = err_index_r;
        overflow_nxt_s   = overflow_r;
        p1_nxt_s         = p1_r;
        p2_nxt_s         = p2_r;
        if (seq_start) begin
            // A dropped start term belongs to the new sequence, so it may
            // set overflow even as the old status is cleared.
            err_nxt_s       = 1'b0;
            err_index_nxt_s = {IDXW{1'b0}};
            overflow_nxt_s  = drop_s;
            p2_nxt_s        = {WIDTH{1'b0}};
            if (in_valid) begin
                term_count_nxt_s = CNT_ONE;
                p1_nxt_s         = in_data;
            end else begin
                term_count_nxt_s = {IDXW{1'b0}};
                p1_nxt_s         = {WIDTH{1'b0}};
            end
        end else if (in_valid) begin
            if (term_count_r != CNT_MAX) begin
                term_count_nxt_s = term_count_r + CNT_ONE;
            end else begin
                term_count_nxt_s = term_count_r;
            end
            if (mismatch_s && !err_r) begin
                err_nxt_s       = 1'b1;
                err_index_nxt_s = term_count_r;
            end else begin
                err_nxt_s       = err_r;
                err_index_nxt_s = err_index_r;
            end
            if (drop_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                overflow_nxt_s = overflow_r;
            end
            // The received value feeds history even when it mismatched.
            p2_nxt_s = p1_r;
            p1_nxt_s = in_data;
        end else begin
            term_count_nxt_s = term_count_r;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= {LW{1'b0}};
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            term_count_r <= {IDXW{1'b0}};
            err_r        <= 1'b0;
            err_index_r  <= {IDXW{1'b0}};
            overflow_r   <= 1'b0;
            p1_r         <= {WIDTH{1'b0}};
            p2_r         <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            level_r      <= level_nxt_s;
            full_r       <= full_nxt_s;
            empty_r      <= empty_nxt_s;
            term_count_r <= term_count_nxt_s;
            err_r        <= err_nxt_s;
            err_index_r  <= err_index_nxt_s;
            overflow_r   <= overflow_nxt_s;
            p1_r         <= p1_nxt_s;
            p2_r         <= p2_nxt_s;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (rst && push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Head presentation: zero while empty so stale storage never leaks out.
    always_comb begin
        out_valid = ~empty_r;
        if (empty_r) begin
            out_data = {WIDTH{1'b0}};
        end else begin
            out_data = mem_r[rd_ptr_r];
        end
    end

    // Registered status to ports.
    always_comb begin
        full       = full_r;
        empty      = empty_r;
        level      = level_r;
        term_count = term_count_r;
        err        = err_r;
        err_index  = err_index_r;
        overflow   = overflow_r;
    end

endmodule

// File: tb/tb_fib_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_fib_seq_checker: scenario tasks with inline checks against constants and
// a queue-based reference model of the checker (sequence list + FIFO queue).
// -----------------------------------------------------------------------------
module tb_fib_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       seq_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic [7:0] term_count;
    logic       err;
    logic [7:0] err_index;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [7:0] m_fifo[$];
    logic [7:0] m_seq[$];
    int         m_cnt;
    bit         m_err;
    int         m_eidx;
    bit         m_ovf;

    fib_seq_checker #(.WIDTH(8), .DEPTH(8), .IDXW(8)) dut (
        .clk(clk), .rst(rst), .seq_start(seq_start), .in_valid(in_valid),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .full(full), .empty(empty), .level(level),
        .term_count(term_count), .err(err), .err_index(err_index),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_fifo.delete();
        m_seq.delete();
        m_cnt  = 0;
        m_err  = 1'b0;
        m_eidx = 0;
        m_ovf  = 1'b0;
    endtask

    // Advance the model by one clock using the rules of the checker.
    task automatic model_step(input bit sv, input bit iv, input logic [7:0] d, input bit ordy);
        bit         pop;
        bit         push;
        logic [7:0] want;
        pop  = (m_fifo.size() != 0) && ordy;
        push = iv && ((m_fifo.size() < 8) || pop);
        if (sv) begin
            m_seq.delete();
            m_cnt  = 0;
            m_err  = 1'b0;
            m_eidx = 0;
            m_ovf  = 1'b0;
        end
        if (iv) begin
            if (m_cnt >= 2) begin
                want = m_seq[m_seq.size()-1] + m_seq[m_seq.size()-2];
                if (d != want && !m_err) begin
                    m_err  = 1'b1;
                    m_eidx = m_cnt;
                end
            end
            m_seq.push_back(d);
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (!push) m_ovf = 1'b1;
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(d);
    endtask

    task automatic cycle(input bit sv, input bit iv, input logic [7:0] d, input bit ordy);
        seq_start = sv;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        model_step(sv, iv, d, ordy);
        @(posedge clk);
        #1;
        seq_start = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic do_reset(input bit iv);
        rst      = 1'b0;
        in_valid = iv;
        in_data  = 8'd77;
        model_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        seq_start = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'd0;
        do_reset(1'b0);
        do_reset(1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (full !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL reset_flags got full=%0b empty=%0b exp 0/1", full, empty); end
        checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (term_count !== 8'd0 || err !== 1'b0 || err_index !== 8'd0 || overflow !== 1'b0) begin
            failures++; $display("FAIL reset_status got cnt=%0d err=%0b idx=%0d ovf=%0b exp all 0", term_count, err, err_index, overflow);
        end
    endtask

    task automatic test_wrap_sequence();
        logic [7:0] t [14] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                               8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};
        for (int i = 0; i < 14; i++) begin
            cycle(i == 0, 1'b1, t[i], 1'b1);
            checks++; if (out_valid !== 1'b1 || out_data !== t[i]) begin
                failures++; $display("FAIL wrap_head i=%0d got v=%0b d=%0d exp v=1 d=%0d", i, out_valid, out_data, t[i]);
            end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL wrap_err i=%0d got=%0b exp=0", i, err); end
        end
        checks++; if (term_count !== 8'd14) begin failures++; $display("FAIL wrap_count got=%0d exp=14", term_count); end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
        checks++; if (empty !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL wrap_drain got empty=%0b level=%0d exp 1/0", empty, level); end
    endtask

    task automatic test_mismatch();
        logic [7:0] t [6] = '{8'd1, 8'd2, 8'd3, 8'd6, 8'd9, 8'd15};
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 1'b1, t[i], 1'b1);
            checks++; if (err !== (i >= 3)) begin failures++; $display("FAIL mis_err i=%0d got=%0b exp=%0b", i, err, (i >= 3)); end
            if (i >= 3) begin
                checks++; if (err_index !== 8'd3) begin failures++; $display("FAIL mis_index i=%0d got=%0d exp=3", i, err_index); end
            end
        end
    endtask

    task automatic test_seq_restart();
        logic [7:0] exp_q [4] = '{8'd15, 8'd1, 8'd2, 8'd3};
        cycle(1'b1, 1'b1, 8'd1, 1'b0);
        checks++; if (err !== 1'b0 || overflow !== 1'b0 || term_count !== 8'd1) begin
            failures++; $display("FAIL restart_status got err=%0b ovf=%0b cnt=%0d exp 0/0/1", err, overflow, term_count);
        end
        cycle(1'b0, 1'b1, 8'd2, 1'b0);
        cycle(1'b0, 1'b1, 8'd3, 1'b0);
        checks++; if (err !== 1'b0 || term_count !== 8'd3 || level !== 4'd4) begin
            failures++; $display("FAIL restart_clean got err=%0b cnt=%0d level=%0d exp 0/3/4", err, term_count, level);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_q[i]) begin
                failures++; $display("FAIL restart_drain i=%0d got v=%0b d=%0d exp d=%0d", i, out_valid, out_data, exp_q[i]);
            end
            cycle(1'b0, 1'b0, 8'd0, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL restart_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_overflow();
        logic [7:0] t [9] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55};
        for (int i = 0; i < 9; i++) begin
            cycle(i == 0, 1'b1, t[i], 1'b0);
            if (i == 7) begin
                checks++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0 || empty !== 1'b0) begin
                    failures++; $display("FAIL ovf_full got full=%0b level=%0d ovf=%0b empty=%0b exp 1/8/0/0", full, level, overflow, empty);
                end
            end
        end
        checks++; if (overflow !== 1'b1 || level !== 4'd8 || term_count !== 8'd9 || err !== 1'b0) begin
            failures++; $display("FAIL ovf_drop got ovf=%0b level=%0d cnt=%0d err=%0b exp 1/8/9/0", overflow, level, term_count, err);
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_data !== t[i]) begin failures++; $display("FAIL ovf_drain i=%0d got=%0d exp=%0d", i, out_data, t[i]); end
            cycle(1'b0, 1'b0, 8'd0, 1'b1);
        end
        checks++; if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0) begin
            failures++; $display("FAIL ovf_empty got empty=%0b level=%0d full=%0b exp 1/0/0", empty, level, full);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] t [9] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34, 8'd55};
        for (int i = 0; i < 8; i++) cycle(i == 0, 1'b1, t[i], 1'b0);
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fpp_full got=%0b exp=1", full); end
        cycle(1'b0, 1'b1, t[8], 1'b1);
        checks++; if (level !== 4'd8 || overflow !== 1'b0 || full !== 1'b1 || out_data !== 8'd2) begin
            failures++; $display("FAIL fpp_same got level=%0d ovf=%0b full=%0b head=%0d exp 8/0/1/2", level, overflow, full, out_data);
        end
        for (int i = 1; i < 9; i++) begin
            checks++; if (out_data !== t[i]) begin failures++; $display("FAIL fpp_drain i=%0d got=%0d exp=%0d", i, out_data, t[i]); end
            cycle(1'b0, 1'b0, 8'd0, 1'b1);
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fpp_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] t [5] = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd10};
        for (int i = 0; i < 5; i++) cycle(i == 0, 1'b1, t[i], 1'b0);
        checks++; if (level !== 4'd5 || err !== 1'b1 || err_index !== 8'd2) begin
            failures++; $display("FAIL mrst_pre got level=%0d err=%0b idx=%0d exp 5/1/2", level, err, err_index);
        end
        do_reset(1'b1);
        checks++; if (empty !== 1'b1 || level !== 4'd0 || out_valid !== 1'b0 || out_data !== 8'd0) begin
            failures++; $display("FAIL mrst_fifo got empty=%0b level=%0d v=%0b d=%0d exp 1/0/0/0", empty, level, out_valid, out_data);
        end
        checks++; if (term_count !== 8'd0 || err !== 1'b0) begin
            failures++; $display("FAIL mrst_status got cnt=%0d err=%0b exp 0/0", term_count, err);
        end
        cycle(1'b0, 1'b1, 8'd1, 1'b1);
        cycle(1'b0, 1'b1, 8'd2, 1'b1);
        cycle(1'b0, 1'b1, 8'd3, 1'b1);
        checks++; if (err !== 1'b0 || term_count !== 8'd3 || out_data !== 8'd3) begin
            failures++; $display("FAIL mrst_resume got err=%0b cnt=%0d head=%0d exp 0/3/3", err, term_count, out_data);
        end
        cycle(1'b0, 1'b0, 8'd0, 1'b1);
    endtask

    task automatic test_random();
        bit         sv, iv, ordy;
        logic [7:0] d;
        logic [7:0] exp_d;
        for (int c = 0; c < 600; c++) begin
            sv   = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < (c < 300 ? 3 : 6));
            if (!sv && m_seq.size() >= 2 && $urandom_range(0, 19) != 0)
                d = m_seq[m_seq.size()-1] + m_seq[m_seq.size()-2];
            else
                d = 8'($urandom_range(0, 255));
            cycle(sv, iv, d, ordy);
            exp_d = (m_fifo.size() != 0) ? m_fifo[0] : 8'd0;
            checks++; if (out_valid !== (m_fifo.size() != 0) || out_data !== exp_d) begin
                failures++; $display("FAIL rnd_head c=%0d got v=%0b d=%0d exp v=%0b d=%0d", c, out_valid, out_data, (m_fifo.size() != 0), exp_d);
            end
            checks++; if (level !== 4'(m_fifo.size()) || full !== (m_fifo.size() == 8) || empty !== (m_fifo.size() == 0)) begin
                failures++; $display("FAIL rnd_flags c=%0d got level=%0d full=%0b empty=%0b exp level=%0d", c, level, full, empty, m_fifo.size());
            end
            checks++; if (term_count !== 8'(m_cnt) || err !== m_err || overflow !== m_ovf) begin
                failures++; $display("FAIL rnd_status c=%0d got cnt=%0d err=%0b ovf=%0b exp cnt=%0d err=%0b ovf=%0b",
                                     c, term_count, err, overflow, m_cnt, m_err, m_ovf);
            end
            if (m_err) begin
                checks++; if (err_index !== 8'(m_eidx)) begin
                    failures++; $display("FAIL rnd_index c=%0d got=%0d exp=%0d", c, err_index, m_eidx);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        seq_start = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        #2;
        test_reset();
        test_wrap_sequence();
        test_mismatch();
        test_seq_restart();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
